// File: rtl/mem_resp_pkg.sv
// Shared constants and FSM state encoding for the byte-wide memory responder.
package mem_resp_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int WS_DEF = 0;
  localparam int CW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_byte_ram.sv
// DEPTH x DW storage with one synchronous write port and one registered read port.
// No reset: array contents survive a responder reset.
module byte_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write at a time, inserts WAIT_STATES wait cycles,
// pulses memready on completion and offers a side-band preload port.
//
// state | meaning
// IDLE  | waiting for a request; preloads allowed here only
// WAIT  | request latched, counting down wait states
// RESP  | access done, memready high for this one cycle
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_STATES = WS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] memdata,
  output logic          memready,
  output logic          busy,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_adr,
  input  logic [DW-1:0] ld_data,
  output logic          err
);

  localparam int             LOAD_I   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [CW-1:0]  CNT_LOAD = LOAD_I[CW-1:0];

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic          memready_q;
  logic          busy_q;
  logic          err_q;
  logic          rd_valid_q;

  logic          req;
  logic          do_access;
  logic          acc_write;
  logic [AW-1:0] acc_adr;
  logic [DW-1:0] acc_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  assign req = memread | memwrite;

  // With zero wait states the access uses the live bus on the accepting edge.
  always_comb begin
    do_access = 1'b0;
    case (state_q)
      IDLE:    do_access = req && (WAIT_STATES == 0);
      WAIT:    do_access = (cnt_q == '0);
      default: do_access = 1'b0;
    endcase
  end

  assign acc_write = (state_q == IDLE) ? memwrite  : wr_q;
  assign acc_adr   = (state_q == IDLE) ? adr       : adr_q;
  assign acc_wdata = (state_q == IDLE) ? writedata : wdata_q;

  assign ram_we    = ~reset & ((do_access & acc_write) | ((state_q == IDLE) & ~req & ld_en));
  assign ram_re    = ~reset & do_access & ~acc_write;
  assign ram_waddr = do_access ? acc_adr   : ld_adr;
  assign ram_wdata = do_access ? acc_wdata : ld_data;

  byte_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(acc_adr),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      adr_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      memready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      memready_q <= 1'b0;
      if (ram_re) rd_valid_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req) begin
            adr_q   <= adr;
            wdata_q <= writedata;
            wr_q    <= memwrite;
            busy_q  <= 1'b1;
            if ((memread & memwrite) | ld_en) err_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q    <= RESP;
              memready_q <= 1'b1;
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ld_en) err_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q    <= RESP;
            memready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (ld_en) err_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // memdata reads as zero after reset until the first read completes.
  assign memdata  = rd_valid_q ? ram_rdata : '0;
  assign memready = memready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: four responders (WAIT_STATES 0..3) share one request bus;
// each scenario checks the instance whose wait-state count it targets.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       memread, memwrite, ld_en;
  logic [7:0] adr, writedata, ld_adr, ld_data;

  logic [7:0] memdata_w  [4];
  logic       memready_w [4];
  logic       busy_w     [4];
  logic       err_w      [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(.AW(8), .DW(8), .WAIT_STATES(g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .memread  (memread),
      .memwrite (memwrite),
      .adr      (adr),
      .writedata(writedata),
      .memdata  (memdata_w[g]),
      .memready (memready_w[g]),
      .busy     (busy_w[g]),
      .ld_en    (ld_en),
      .ld_adr   (ld_adr),
      .ld_data  (ld_data),
      .err      (err_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_adr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Drive one request for a single edge, move the bus elsewhere, then count
  // edges (accepting edge included) until the chosen instance pulses memready.
  task automatic txn(input int idx, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] post_a, output int lat);
    memread = rd; memwrite = wr; adr = a; writedata = d;
    tick();
    memread = 1'b0; memwrite = 1'b0; adr = post_a; writedata = ~d;
    lat = 1;
    while (!memready_w[idx] && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; ld_en = 1'b0;
    adr = '0; writedata = '0; ld_adr = '0; ld_data = '0;
    tick(); tick();
    check("rst_memready", {31'd0, memready_w[0]}, 32'd0);
    check("rst_memdata",  {24'd0, memdata_w[0]},  32'd0);
    check("rst_busy",     {31'd0, busy_w[3]},     32'd0);
    check("rst_err",      {31'd0, err_w[0]},      32'd0);
    reset = 1'b0;
    tick();

    preload(8'h00, 8'h05);
    preload(8'h10, 8'h00);
    preload(8'h01, 8'h11);
    preload(8'h40, 8'h44);
    preload(8'hFF, 8'hE7);
    tick();

    // Preload then read, zero wait states
    txn(0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, lat);
    check("t2_latency", lat, 32'd1);
    check("t2_data", {24'd0, memdata_w[0]}, 32'h05);
    tick();
    check("t2_ready_low", {31'd0, memready_w[0]}, 32'd0);
    settle();

    // Reset during WAIT of a write on the 3-wait-state instance
    memwrite = 1'b1; adr = 8'h10; writedata = 8'hAA;
    tick();
    memwrite = 1'b0;
    tick();
    check("t1_busy_wait", {31'd0, busy_w[3]}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_ready", {31'd0, memready_w[3]}, 32'd0);
    check("t1_rst_data",  {24'd0, memdata_w[3]},  32'd0);
    check("t1_rst_busy",  {31'd0, busy_w[3]},     32'd0);
    tick();
    reset = 1'b0;
    txn(3, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, lat);
    check("t1_latency", lat, 32'd4);
    check("t1_read_old", {24'd0, memdata_w[3]}, 32'h00);
    check("t1_ws0_wrote", {24'd0, memdata_w[0]}, 32'hAA);
    settle();

    // Two wait states, address moved after acceptance
    txn(2, 1'b0, 1'b1, 8'h7F, 8'h3C, 8'h01, lat);
    check("t3_wr_latency", lat, 32'd3);
    settle();
    txn(2, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h00, lat);
    check("t3_rd_latency", lat, 32'd3);
    check("t3_rd_7f", {24'd0, memdata_w[2]}, 32'h3C);
    settle();
    txn(2, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, lat);
    check("t3_rd_01", {24'd0, memdata_w[2]}, 32'h11);
    settle();

    // Simultaneous read and write
    txn(0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, lat);
    check("t4_prior", {24'd0, memdata_w[0]}, 32'h05);
    settle();
    check("t4_err_before", {31'd0, err_w[0]}, 32'd0);
    txn(0, 1'b1, 1'b1, 8'h20, 8'h99, 8'h00, lat);
    check("t4_latency", lat, 32'd1);
    check("t4_data_held", {24'd0, memdata_w[0]}, 32'h05);
    check("t4_err", {31'd0, err_w[0]}, 32'd1);
    settle();
    check("t4_err_sticky", {31'd0, err_w[0]}, 32'd1);
    txn(0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h00, lat);
    check("t4_rd_20", {24'd0, memdata_w[0]}, 32'h99);
    settle();

    // Preload attempted while busy
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_err_cleared", {31'd0, err_w[1]}, 32'd0);
    memwrite = 1'b1; adr = 8'h50; writedata = 8'h12;
    tick();
    memwrite = 1'b0;
    ld_en = 1'b1; ld_adr = 8'h40; ld_data = 8'h77;
    tick();
    ld_en = 1'b0;
    check("t5_ready", {31'd0, memready_w[1]}, 32'd1);
    check("t5_err", {31'd0, err_w[1]}, 32'd1);
    settle();
    txn(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, lat);
    check("t5_latency", lat, 32'd2);
    check("t5_rd_40", {24'd0, memdata_w[1]}, 32'h44);
    settle();
    txn(1, 1'b1, 1'b0, 8'h50, 8'h00, 8'h00, lat);
    check("t5_rd_50", {24'd0, memdata_w[1]}, 32'h12);
    settle();

    // Read held across RESP
    memread = 1'b1; adr = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_ready_%0d", i), {31'd0, memready_w[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check($sformatf("t6_data_%0d", i), {24'd0, memdata_w[0]}, 32'hE7);
    end
    memread = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
